// File: rtl/vco_period_meter.sv
// -----------------------------------------------------------------------------
// vco_period_meter
//
// Measures the oscillation period of a fixed-point VCO sample stream.
// The block detects rising zero crossings with hysteresis. It counts the
// valid samples between consecutive crossings and sums NPER = 2**LOG2_NPER
// consecutive periods into one registered estimate.
//
// Handshake: in_valid qualifies sample. When in_valid is low, the cycle is
// ignored and all measurement state holds. There is no back-pressure.
// period_valid and timeout are single-cycle pulses and never coincide.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   in_valid     in   sample qualifier
//   sample       in   DATA_W signed VCO output sample
//   period       out  CNT_W+LOG2_NPER sum of the last NPER periods
//   period_valid out  pulse when period updates
//   locked       out  high once an estimate exists since reset/timeout
//   timeout      out  pulse when no crossing arrives within the count limit
//   dbg_state    out  current FSM state (0 = SEEK, 1 = MEASURE)
// -----------------------------------------------------------------------------
module vco_period_meter #(
    parameter int DATA_W    = 14,
    parameter int CNT_W     = 16,
    parameter int LOG2_NPER = 2,
    parameter int HYST      = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          sample,
    output logic [CNT_W+LOG2_NPER-1:0] period,
    output logic                       period_valid,
    output logic                       locked,
    output logic                       timeout,
    output logic                       dbg_state
);

    localparam int PW = CNT_W + LOG2_NPER;

    // Count value whose successor (2^CNT_W-1) triggers a timeout.
    localparam logic [CNT_W-1:0]     CNT_LAST = ~(CNT_W'(1));
    localparam logic [LOG2_NPER-1:0] K_LAST   = '1;
    localparam logic signed [DATA_W-1:0] NEG_HYST = DATA_W'(-HYST);

    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 armed_q, armed_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic [LOG2_NPER-1:0] k_q, k_d;
    logic [PW-1:0]        period_q, period_d;
    logic                 period_valid_q, period_valid_d;
    logic                 locked_q, locked_d;
    logic                 timeout_q, timeout_d;

    logic                 arm_hit;
    logic                 crossing;
    logic [CNT_W-1:0]     p_len;
    logic [PW-1:0]        acc_sum;

    // Strictly below -HYST arms; a sample equal to -HYST does not.
    assign arm_hit  = $signed(sample) < NEG_HYST;
    // Rising crossing: armed and the sign bit clear (sample >= 0).
    assign crossing = armed_q && !sample[DATA_W-1];
    // The measured period includes the crossing sample itself.
    assign p_len    = cnt_q + 1'b1;
    assign acc_sum  = acc_q + PW'(p_len);

    always_comb begin
        state_d        = state_q;
        armed_d        = armed_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        k_d            = k_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = 1'b0;

        if (in_valid) begin
            if (crossing) begin
                armed_d = 1'b0;
            end else if (arm_hit) begin
                armed_d = 1'b1;
            end

            case (state_q)
                SEEK: begin
                    if (crossing) begin
                        state_d = MEASURE;
                        cnt_d   = '0;
                        acc_d   = '0;
                        k_d     = '0;
                    end
                end
                MEASURE: begin
                    // A crossing wins over a timeout on the same sample.
                    if (crossing) begin
                        cnt_d = '0;
                        if (k_q == K_LAST) begin
                            period_d       = acc_sum;
                            period_valid_d = 1'b1;
                            locked_d       = 1'b1;
                            acc_d          = '0;
                            k_d            = '0;
                        end else begin
                            acc_d = acc_sum;
                            k_d   = k_q + 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        // period deliberately keeps its last value.
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        state_d   = SEEK;
                        armed_d   = 1'b0;
                        cnt_d     = '0;
                        acc_d     = '0;
                        k_d       = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SEEK;
            armed_q        <= 1'b0;
            cnt_q          <= '0;
            acc_q          <= '0;
            k_q            <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            armed_q        <= armed_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            k_q            <= k_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_vco_period_meter.sv
// -----------------------------------------------------------------------------
// tb_vco_period_meter
//
// Directed bench for vco_period_meter with default parameters.
// Table rows describe square-wave scenarios with their expected estimate and
// pulse spacing. Hand-written sequences cover the arming threshold, timeout,
// relock, and reset in the middle of a run. Expected periods are queued in
// exp_q and popped on every period_valid pulse.
// -----------------------------------------------------------------------------
module tb_vco_period_meter;

    localparam int PW = 18;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [13:0]   sample;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          timeout;
    logic          dbg_state;

    vco_period_meter dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .sample       (sample),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [PW-1:0] exp_q[$];
    int checks;
    int errors;
    int cycle;
    int last_pv_cycle;
    int exp_spacing;
    int pv_seen;
    int to_seen;

    typedef struct {
        int p_a;
        int p_b;
        int n_periods;
        bit gap;
        int exp_period;
        int exp_space;
        int exp_count;
    } row_t;

    row_t rows[3];

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, look at outputs 1 time unit after the rising edge.
    task automatic step(input int s, input bit v);
        logic [PW-1:0] e;
        @(negedge clk);
        sample   = 14'(s);
        in_valid = v;
        @(posedge clk);
        #1;
        cycle++;
        if (period_valid && timeout) check(1'b0, "pv_timeout_overlap", 1, 0);
        if (timeout) to_seen++;
        if (period_valid) begin
            pv_seen++;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_period_valid", longint'(period), 0);
            end else begin
                e = exp_q.pop_front();
                check(period == e, "period", longint'(period), longint'(e));
            end
            if (exp_spacing != 0 && last_pv_cycle >= 0)
                check(cycle - last_pv_cycle == exp_spacing, "pv_spacing",
                      cycle - last_pv_cycle, exp_spacing);
            last_pv_cycle = cycle;
        end
    endtask

    task automatic put(input int s, input bit gap);
        if (gap) step(int'($urandom_range(0, 16383)), 1'b0);
        step(s, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check(period == '0, {tag, "_period"}, longint'(period), 0);
        check(period_valid == 1'b0, {tag, "_period_valid"}, longint'(period_valid), 0);
        check(locked == 1'b0, {tag, "_locked"}, longint'(locked), 0);
        check(timeout == 1'b0, {tag, "_timeout"}, longint'(timeout), 0);
    endtask

    // A prelude of lows to arm, then per period: p/2 highs (the first is the
    // crossing) followed by p/2 lows.
    task automatic drive_wave(input int p_a, input int p_b, input int n, input bit gap, input bit prelude);
        int p;
        if (prelude) for (int j = 0; j < 10; j++) put(-1000, gap);
        for (int i = 0; i < n; i++) begin
            p = (i % 2 == 1) ? p_b : p_a;
            for (int j = 0; j < p / 2; j++) put(1000, gap);
            for (int j = 0; j < p / 2; j++) put(-1000, gap);
        end
    endtask

    initial begin
        int pv0;
        checks        = 0;
        errors        = 0;
        cycle         = 0;
        last_pv_cycle = -1;
        exp_spacing   = 0;
        pv_seen       = 0;
        to_seen       = 0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        sample        = '0;

        // n_periods = 13 gives 1 reference crossing + 12 periods = 3 estimates.
        rows[0] = '{p_a: 20, p_b: 20, n_periods: 13, gap: 1'b0, exp_period: 80, exp_space: 80,  exp_count: 3};
        rows[1] = '{p_a: 20, p_b: 20, n_periods: 13, gap: 1'b1, exp_period: 80, exp_space: 160, exp_count: 3};
        rows[2] = '{p_a: 10, p_b: 12, n_periods: 13, gap: 1'b0, exp_period: 44, exp_space: 44,  exp_count: 3};

        step(0, 1'b0);
        step(0, 1'b0);
        reset = 1'b0;
        check_idle_outputs("reset");
        check(dbg_state == 1'b0, "reset_state", longint'(dbg_state), 0);

        // table-driven scenarios
        for (int r = 0; r < 3; r++) begin
            do_reset();
            check_idle_outputs("row_reset");
            last_pv_cycle = -1;
            exp_spacing   = rows[r].exp_space;
            pv0           = pv_seen;
            for (int e = 0; e < rows[r].exp_count; e++) exp_q.push_back(PW'(rows[r].exp_period));
            drive_wave(rows[r].p_a, rows[r].p_b, rows[r].n_periods, rows[r].gap, 1'b1);
            check(pv_seen - pv0 == rows[r].exp_count, "row_pv_count", pv_seen - pv0, rows[r].exp_count);
            check(locked == 1'b1, "row_locked", longint'(locked), 1);
            check(exp_q.size() == 0, "row_exp_left", exp_q.size(), 0);
            exp_q.delete();
        end
        exp_spacing = 0;

        // arming boundary: -64 must not arm, -65 must, and 0 counts as a crossing
        do_reset();
        for (int j = 0; j < 5; j++) step(-64, 1'b1);
        for (int j = 0; j < 5; j++) step(1000, 1'b1);
        check(dbg_state == 1'b0, "arm_eq_hyst_no_cross", longint'(dbg_state), 0);
        for (int j = 0; j < 3; j++) step(-65, 1'b1);
        step(0, 1'b1);
        check(dbg_state == 1'b1, "arm_below_hyst_cross", longint'(dbg_state), 1);

        // timeout after lock: 9 periods (2 estimates) plus one more crossing
        do_reset();
        pv0 = pv_seen;
        exp_q.push_back(PW'(80));
        exp_q.push_back(PW'(80));
        drive_wave(20, 20, 9, 1'b0, 1'b1);
        step(1000, 1'b1);
        check(pv_seen - pv0 == 2, "to_pre_pv_count", pv_seen - pv0, 2);
        check(locked == 1'b1, "to_pre_locked", longint'(locked), 1);
        to_seen = 0;
        for (int j = 1; j < 65535; j++) step((j % 2 == 1) ? 50 : -50, 1'b1);
        check(to_seen == 0, "to_early", to_seen, 0);
        step(-50, 1'b1);
        check(timeout == 1'b1, "to_pulse", longint'(timeout), 1);
        check(locked == 1'b0, "to_locked_drop", longint'(locked), 0);
        check(period == PW'(80), "to_period_held", longint'(period), 80);
        check(dbg_state == 1'b0, "to_state_seek", longint'(dbg_state), 0);
        step(50, 1'b0);
        check(timeout == 1'b0, "to_single_cycle", longint'(timeout), 0);
        // noise in SEEK must never time out
        for (int j = 0; j < 100; j++) step((j % 2 == 1) ? 50 : -50, 1'b1);
        check(to_seen == 1, "to_count", to_seen, 1);

        // relock: 5 crossings give one estimate of 80
        pv0 = pv_seen;
        exp_q.push_back(PW'(80));
        drive_wave(20, 20, 5, 1'b0, 1'b1);
        check(pv_seen - pv0 == 1, "relock_pv_count", pv_seen - pv0, 1);
        check(locked == 1'b1, "relock_locked", longint'(locked), 1);

        // reset one cycle after the 3rd crossing of a locked run
        do_reset();
        pv0 = pv_seen;
        exp_q.push_back(PW'(80));
        drive_wave(20, 20, 7, 1'b0, 1'b1);  // lock at crossing 5, crossings 6 and 7 follow
        step(1000, 1'b1);                   // 3rd crossing after lock (acc partial)
        step(1000, 1'b1);
        do_reset();
        check_idle_outputs("midrun_reset");
        check(pv_seen - pv0 == 1, "midrun_pre_pv_count", pv_seen - pv0, 1);
        pv0 = pv_seen;
        exp_q.push_back(PW'(80));
        drive_wave(20, 20, 4, 1'b0, 1'b1);  // only 4 crossings: no estimate yet
        check(pv_seen - pv0 == 0, "midrun_no_early_pv", pv_seen - pv0, 0);
        step(1000, 1'b1);                   // 5th fresh crossing
        check(pv_seen - pv0 == 1, "midrun_first_pv", pv_seen - pv0, 1);
        check(exp_q.size() == 0, "final_exp_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vco_period_meter.md
# vco_period_meter

Measures the oscillation period of the fixed-point VCO model's output sample stream. It detects rising zero crossings with hysteresis, counts valid samples between crossings, and sums a power-of-two number of consecutive periods. The registered period estimate is the measurement-side counterpart to the VCO: the VCO turns a control word into a waveform, and this block turns the waveform back into a period figure for closed-loop and verification use.

## Interface
- DATA_W, 14, sample width, two's complement
- CNT_W, 16, per-period sample counter width
- LOG2_NPER, 2, log2 of the number of periods summed per estimate (NPER = 4)
- HYST, 64, arming threshold magnitude, 0 .. 2^(DATA_W-1)-1
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  sample qualifier; cycles with in_valid low are ignored entirely
- sample  in  DATA_W  signed VCO output sample
- period  out  CNT_W+LOG2_NPER  sum of the last NPER measured periods, in valid samples
- period_valid  out  1  single-cycle pulse when period updates
- locked  out  1  high once at least one estimate has been produced since the last reset or timeout
- timeout  out  1  single-cycle pulse when no crossing occurs within the count limit

## Operation
- Only cycles with in_valid=1 are counted; in_valid=0 cycles leave all state unchanged.
- Arming: `armed` is set on a valid sample with signed sample < -HYST. A sample equal to -HYST does not arm.
- Crossing: a valid sample with armed=1 and sample >= 0 (sign bit clear). This clears armed on the same edge.
- States:
  - SEEK: no reference crossing yet; cnt, acc and k are held at 0. A crossing moves the block to MEASURE with cnt=0, acc=0, k=0.
  - MEASURE, non-crossing valid sample: cnt <= cnt+1.
  - MEASURE, crossing: p = cnt+1, so the measured period includes the crossing sample. cnt <= 0.
    - If k < NPER-1: acc <= acc+p and k <= k+1.
    - If k == NPER-1: period <= acc+p, period_valid pulses, locked <= 1, acc <= 0, k <= 0.
- Timeout: in MEASURE, a non-crossing valid sample with cnt+1 == 2^CNT_W-1 has the following effect:
  - timeout pulses and locked <= 0.
  - The state returns to SEEK with armed, cnt, acc and k cleared.
  - period holds its last value.
- A crossing on the sample where cnt+1 == 2^CNT_W-1 is a legal period and does not time out. A crossing always takes priority over timeout.
- Arithmetic is unsigned for cnt, acc and period. acc is CNT_W+LOG2_NPER wide and cannot overflow. Sign handling applies only to the arm and crossing compares.
- No timeout while in SEEK.

## Timing
- All outputs are registered. Reset values: period=0, period_valid=0, locked=0, timeout=0. Internal reset values: state=SEEK, armed=0, cnt=0, acc=0, k=0.
- Latency: period and period_valid take their new values at the same rising edge that samples the completing crossing sample. They are visible the following cycle.
- period_valid and timeout are high for exactly one cycle per event and are never high together.
- Reset mid-measurement discards any partial cnt/acc/k. After reset, the first estimate needs 1 reference crossing plus NPER further crossings.
- Throughput: one sample per cycle, no back-pressure.

## Test plan
- Square wave +1000×10 / -1000×10, in_valid always 1, defaults: first period_valid on the 5th rising crossing, period=80, locked=1. Then period=80 every 80 valid samples.
- Same wave with in_valid=0 on every other cycle (invalid cycles carry garbage): estimates unchanged, period=80; period_valid spacing 160 cycles.
- Alternating periods 10,12,10,12 (half high / half low, ±1000): period=44.
- Arming boundary with HYST=64:
  - low level -64 then +1000: no crossing.
  - low level -65 then 0: crossing counted.
- After lock, hold the sample at ±50 noise: timeout pulses when the 65535th valid sample since the last crossing arrives. locked drops and period keeps 80. A restored square wave relocks after 5 crossings.
- Reset asserted one cycle after the 3rd crossing of a locked run: all outputs 0 the next cycle. No period_valid until 5 fresh crossings; the first value is 80.
